// File: rtl/axi_spi_fifo_pkg.sv
// Shared helpers for the AXI/SPI dual-clock FIFO.
// - bin2gray / gray2bin : pointer code conversion. Operands are 32 bits wide, so
//   any pointer of up to 32 bits can be passed in zero-extended and the result
//   truncated back to its own width.
// - RST_* constants     : reset values of the FIFO status outputs.
package axi_spi_fifo_pkg;

  localparam int   CODE_W     = 32;
  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_STICKY = 1'b0;
  localparam logic RST_VALID  = 1'b0;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the lower bits of the result unchanged, so
  // zero-extending a narrower pointer gives the correct answer.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b = g;
    for (int i = 1; i < CODE_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/axi_spi_async_fifo_cdc_sync_bus.sv
// cdc_sync_bus: STAGES-deep flop chain for a gray-coded bus entering clk's domain.
// Ports: clk (destination clock), rst_n (async active-low), d (source bus), q (synchronised bus).
module cdc_sync_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/axi_spi_async_fifo.sv
// axi_spi_async_fifo: dual-clock FIFO, write side on ACLK, read side on SCLK.
// Write ports: wr_en, wr_data, full, almost_full, wr_level, overflow (sticky).
// Read ports : rd_en, rd_data, empty, almost_empty, rd_level, underflow (sticky).
// rst_n asynchronously resets both domains. FWFT=1 turns the read register into
// a prefetched head-of-queue word (empty=0 means rd_data is valid now).
module axi_spi_async_fifo
  import axi_spi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  ACLK,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AFULL_L  = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] AEMPTY_L = PTR_W'(AEMPTY_THRESH);

  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("axi_spi_async_fifo: ADDR_WIDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("axi_spi_async_fifo: SYNC_STAGES must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("axi_spi_async_fifo: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("axi_spi_async_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_bin, wr_gray, wr_bin_nxt, rd_sync, rd_sync_bin;
  logic [PTR_W-1:0] rd_bin, rd_gray, rd_bin_nxt, wr_sync, wr_sync_bin;
  logic             push, pop_mem, mem_empty, out_valid;

  // ---------------- write domain ----------------
  cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rd2wr (
    .clk   (ACLK),
    .rst_n (rst_n),
    .d     (rd_gray),
    .q     (rd_sync)
  );

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign full        = (wr_gray == {~rd_sync[PTR_W-1:PTR_W-2], rd_sync[PTR_W-3:0]});
  assign push        = wr_en & ~full;
  assign wr_bin_nxt  = wr_bin + PTR_W'(1);
  assign rd_sync_bin = PTR_W'(gray2bin(CODE_W'(rd_sync)));
  assign wr_level    = wr_bin - rd_sync_bin;
  assign almost_full = (wr_level >= AFULL_L);

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      overflow <= RST_STICKY;
    end else begin
      if (push) begin
        wr_bin  <= wr_bin_nxt;
        wr_gray <= PTR_W'(bin2gray(CODE_W'(wr_bin_nxt)));
      end
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // ---------------- read domain ----------------
  cdc_sync_bus #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr2rd (
    .clk   (SCLK),
    .rst_n (rst_n),
    .d     (wr_gray),
    .q     (wr_sync)
  );

  assign mem_empty    = (rd_gray == wr_sync);
  assign wr_sync_bin  = PTR_W'(gray2bin(CODE_W'(wr_sync)));
  assign rd_level     = wr_sync_bin - rd_bin;
  assign almost_empty = (rd_level <= AEMPTY_L);
  assign rd_bin_nxt   = rd_bin + PTR_W'(1);

  // In FWFT mode the output register is refilled whenever it is vacant or being
  // consumed this edge; otherwise memory is read only on an accepted pop.
  assign pop_mem = (FWFT != 0) ? (~mem_empty & (~out_valid | rd_en))
                               : (rd_en & ~mem_empty);
  assign empty   = (FWFT != 0) ? ~out_valid : mem_empty;

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      rd_data   <= '0;
      out_valid <= RST_VALID;
      underflow <= RST_STICKY;
    end else begin
      if (pop_mem) begin
        rd_bin    <= rd_bin_nxt;
        rd_gray   <= PTR_W'(bin2gray(CODE_W'(rd_bin_nxt)));
        rd_data   <= mem[rd_bin[ADDR_WIDTH-1:0]];
        out_valid <= 1'b1;
      end else if (rd_en && out_valid && (FWFT != 0)) begin
        out_valid <= 1'b0;
      end
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_spi_async_fifo.sv
module tb_axi_spi_async_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic ACLK = 1'b0;
  logic SCLK = 1'b0;
  logic rst_n = 1'b0;
  int   aclk_half = 5;
  int   sclk_half = 20;

  always #(aclk_half) ACLK = ~ACLK;
  always #(sclk_half) SCLK = ~SCLK;

  // registered-read instance
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic          full, almost_full, overflow, empty, almost_empty, underflow;
  logic [AW:0]   wr_level, rd_level;

  // first-word-fall-through instance
  logic          f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [DW-1:0] f_wr_data = '0, f_rd_data;
  logic          f_full, f_almost_full, f_overflow, f_empty, f_almost_empty, f_underflow;
  logic [AW:0]   f_wr_level, f_rd_level;

  axi_spi_async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .FWFT(0),
                       .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_dut (
    .ACLK(ACLK), .rst_n(rst_n), .SCLK(SCLK),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );

  axi_spi_async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .FWFT(1),
                       .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
    .ACLK(ACLK), .rst_n(rst_n), .SCLK(SCLK),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_almost_full),
    .wr_level(f_wr_level), .overflow(f_overflow),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .empty(f_empty), .almost_empty(f_almost_empty),
    .rd_level(f_rd_level), .underflow(f_underflow)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    logic acc;
    @(negedge ACLK);
    acc     = !full;
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge ACLK);
    #1;
    wr_en = 1'b0;
    if (acc) q.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic was_empty;
    @(negedge SCLK);
    was_empty = empty;
    rd_en     = 1'b1;
    @(posedge SCLK);
    #1;
    rd_en = 1'b0;
    if (!was_empty) chk(tag, rd_data, q.pop_front());
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_aempty"}, 32'(almost_empty), 1);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_wr_level"}, 32'(wr_level), 0);
    chk({tag, "_rd_level"}, 32'(rd_level), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_f_empty"}, 32'(f_empty), 1);
  endtask

  task automatic pulse_reset();
    @(negedge ACLK);
    rst_n = 1'b0;
    #3;
    q.delete();
    check_reset_values("rst_pulse");
    #20;
    rst_n = 1'b1;
    repeat (2) @(posedge SCLK);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] d;

    // ---- reset ----
    #3;
    check_reset_values("reset");
    #50;
    rst_n = 1'b1;
    repeat (2) @(posedge SCLK);
    check_reset_values("post_reset");

    // ---- fill ----
    for (int k = 0; k < DEPTH; k++) begin
      push(32'(k));
      chk("fill_afull", 32'(almost_full), 32'(k + 1 >= 12));
      chk("fill_wr_level", 32'(wr_level), 32'(k + 1));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_overflow_pre", 32'(overflow), 0);
    push(32'h99);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_level_after_drop", 32'(wr_level), 16);

    repeat (SYNC + 2) @(posedge SCLK);
    #1;
    chk("drain_rd_level", 32'(rd_level), 16);
    chk("drain_not_empty", 32'(empty), 0);

    // ---- drain ----
    for (int i = 0; i < DEPTH; i++) pop_chk("drain_data");
    chk("drain_empty", 32'(empty), 1);
    chk("drain_aempty", 32'(almost_empty), 1);
    chk("drain_rd_level0", 32'(rd_level), 0);
    chk("underflow_pre", 32'(underflow), 0);
    pop_chk("extra_pop");
    chk("underflow", 32'(underflow), 1);
    chk("underflow_hold", rd_data, 32'hF);
    repeat (SYNC + 4) @(posedge ACLK);
    #1;
    chk("full_release", 32'(full), 0);
    chk("wr_level_release", 32'(wr_level), 0);

    // ---- FWFT ----
    @(negedge ACLK);
    f_wr_en   = 1'b1;
    f_wr_data = 32'hA5A5_0001;
    @(posedge ACLK);
    #1;
    f_wr_en = 1'b0;
    n = 0;
    while (f_empty && n < SYNC + 2) begin
      @(posedge SCLK);
      #1;
      n++;
    end
    chk("fwft_empty_latency", 32'(f_empty), 0);
    chk("fwft_data", f_rd_data, 32'hA5A5_0001);
    chk("fwft_rd_level", 32'(f_rd_level), 0);
    @(negedge SCLK);
    f_rd_en = 1'b1;
    @(posedge SCLK);
    #1;
    f_rd_en = 1'b0;
    chk("fwft_consumed_empty", 32'(f_empty), 1);
    chk("fwft_no_underflow", 32'(f_underflow), 0);

    // ---- stress with clock-ratio swap ----
    pulse_reset();
    fork
      begin : writer
        int sent, cyc;
        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 5000) begin
          @(negedge ACLK);
          cyc++;
          if ($urandom_range(1) == 1 && !full) begin
            d       = $urandom;
            wr_data = d;
            wr_en   = 1'b1;
            q.push_back(d);
            sent++;
            if (sent == 50) begin
              aclk_half = 20;
              sclk_half = 5;
            end
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge ACLK);
        wr_en = 1'b0;
        chk("stress_sent", 32'(sent), 100);
      end
      begin : reader
        int got, cyc;
        logic take;
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 20000) begin
          @(negedge SCLK);
          cyc++;
          take  = ($urandom_range(1) == 1) && !empty;
          rd_en = take;
          @(posedge SCLK);
          #1;
          if (take) begin
            chk("stress_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("stress_data", rd_data, q.pop_front());
            got++;
          end
          if (wr_level > 5'(DEPTH)) chk("stress_wr_level_range", 32'(wr_level), DEPTH);
        end
        rd_en = 1'b0;
        chk("stress_received", 32'(got), 100);
      end
    join
    chk("stress_overflow", 32'(overflow), 0);
    chk("stress_underflow", 32'(underflow), 0);
    aclk_half = 5;
    sclk_half = 20;

    // ---- reset with data queued ----
    for (int i = 0; i < 7; i++) push(32'hC000_0000 + 32'(i));
    repeat (SYNC + 2) @(posedge SCLK);
    #1;
    chk("queued_rd_level", 32'(rd_level), 7);
    pulse_reset();
    for (int i = 0; i < 3; i++) push(32'h5A00_0000 + 32'(i));
    repeat (SYNC + 2) @(posedge SCLK);
    #1;
    chk("post_rst_rd_level", 32'(rd_level), 3);
    for (int i = 0; i < 3; i++) pop_chk("post_rst_data");
    chk("post_rst_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
